// File: rtl/pwm_pkg.sv
// Shared defaults and FSM encoding for the counter-driven PWM generator.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;
  localparam int PWM_WRAPW = 16;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/cnt_wrap_detect.sv
// Watches an upstream free-running counter and flags its natural wrap
// (all-ones -> zero) and any break in the +1 sequence (reload or hold).
module cnt_wrap_detect #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_wrap,
  output logic             o_disc
);

  logic [WIDTH-1:0] r_prev_q;
  logic             r_prev_valid;
  logic [WIDTH-1:0] w_q_succ;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev_q     <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_prev_q     <= i_q;
      r_prev_valid <= 1'b1;
    end
  end

  // Modulo-2^WIDTH successor, so the wrap itself is never a discontinuity.
  assign w_q_succ = r_prev_q + WIDTH'(1);

  assign o_wrap = r_prev_valid && (r_prev_q == '1) && (i_q == '0);
  assign o_disc = r_prev_valid && (i_q != w_q_succ);

endmodule

// File: rtl/pwm_256_from_cnt.sv
// PWM derived from an external binary counter: locks onto the counter wrap,
// double-buffers duty updates so they only take effect on a period boundary.
module pwm_256_from_cnt
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int WRAPW = PWM_WRAPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             wrap_tick,
  output logic             sync_err,
  output logic [WRAPW-1:0] wrap_cnt,
  output pwm_state_t       dbg_state
);

  pwm_state_t       r_state;
  pwm_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_shadow_valid;
  logic [WIDTH-1:0] r_active_duty;
  logic [WIDTH-1:0] w_eff_duty;
  logic             w_accept;
  logic             w_commit;
  logic             w_wrap;
  logic             w_disc;
  logic             r_pwm;
  logic             r_wrap_tick;
  logic             r_sync_err;
  logic [WRAPW-1:0] r_wrap_cnt;

  cnt_wrap_detect #(
    .WIDTH (WIDTH)
  ) u_detect (
    .i_clk   (clk),
    .i_reset (reset),
    .i_q     (q_in),
    .o_wrap  (w_wrap),
    .o_disc  (w_disc)
  );

  // Handshake: a duty word transfers on any rising edge where duty_valid and
  // duty_ready are both high; ready depends only on the shadow being empty.
  assign w_accept = duty_valid && !r_shadow_valid;
  assign w_commit = w_wrap && r_shadow_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC:    if (w_wrap) w_state_nxt = RUN;
      RUN:     if (w_disc) w_state_nxt = SYNC;
      default: w_state_nxt = SYNC;
    endcase
  end

  // The committing value must already drive the compare on the wrap cycle.
  assign w_eff_duty = w_commit ? r_shadow : r_active_duty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= SYNC;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_active_duty  <= '0;
      r_pwm          <= 1'b0;
      r_wrap_tick    <= 1'b0;
      r_sync_err     <= 1'b0;
      r_wrap_cnt     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pwm       <= (w_state_nxt == RUN) && (q_in < w_eff_duty);
      r_wrap_tick <= w_wrap;
      r_sync_err  <= w_disc;
      if (w_wrap) begin
        r_wrap_cnt <= r_wrap_cnt + WRAPW'(1);
      end
      if (w_commit) begin
        r_active_duty  <= r_shadow;
        r_shadow_valid <= 1'b0;
      end else if (w_accept) begin
        r_shadow       <= duty;
        r_shadow_valid <= 1'b1;
      end
    end
  end

  assign duty_ready = !r_shadow_valid;
  assign pwm_out    = r_pwm;
  assign wrap_tick  = r_wrap_tick;
  assign sync_err   = r_sync_err;
  assign wrap_cnt   = r_wrap_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pwm_256_from_cnt.sv
// Bench for pwm_256_from_cnt: directed period scenarios plus randomized
// counter/duty traffic, all checked against a cycle-level reference model.
module tb_pwm_256_from_cnt;
  import pwm_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  q_in;
  logic [7:0]  duty;
  logic        duty_valid;
  logic        duty_ready;
  logic        pwm_out;
  logic        wrap_tick;
  logic        sync_err;
  logic [15:0] wrap_cnt;
  pwm_state_t  dbg_state;

  logic        s_ready;
  logic        s_pwm;
  logic        s_tick;
  logic        s_err;
  logic [3:0]  s_wrap_cnt;
  pwm_state_t  s_state;

  always #5 clk = ~clk;

  pwm_256_from_cnt dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_tick  (wrap_tick),
    .sync_err   (sync_err),
    .wrap_cnt   (wrap_cnt),
    .dbg_state  (dbg_state)
  );

  // Narrow wrap counter instance so rollover is reachable in few cycles.
  pwm_256_from_cnt #(.WIDTH(8), .WRAPW(4)) dut_w4 (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .duty       (duty),
    .duty_valid (duty_valid),
    .duty_ready (s_ready),
    .pwm_out    (s_pwm),
    .wrap_tick  (s_tick),
    .sync_err   (s_err),
    .wrap_cnt   (s_wrap_cnt),
    .dbg_state  (s_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int hi_cnt = 0;
  int tick_cnt = 0;
  int err_cnt = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_prev < 0: no previous sample; m_pending < 0: no queued duty.
  int m_prev;
  bit m_locked;
  int m_active;
  int m_pending;
  int m_wraps;

  task automatic model_reset();
    m_prev    = -1;
    m_locked  = 1'b0;
    m_active  = 0;
    m_pending = -1;
    m_wraps   = 0;
  endtask

  task automatic model_step();
    int  q;
    int  use_duty;
    bit  is_wrap;
    bit  is_disc;
    bit  hi;
    if (reset) begin
      model_reset();
      exp_q.push_back(3'b000);
      return;
    end
    q        = int'(q_in);
    is_wrap  = (m_prev == 255) && (q == 0);
    is_disc  = (m_prev >= 0) && (q != ((m_prev + 1) % 256));
    use_duty = m_active;
    if (is_wrap && m_pending >= 0) begin
      use_duty  = m_pending;
      m_active  = m_pending;
      m_pending = -1;
    end else if (duty_valid && m_pending < 0) begin
      m_pending = int'(duty);
    end
    if (is_wrap) m_locked = 1'b1;
    else if (is_disc) m_locked = 1'b0;
    if (is_wrap) m_wraps++;
    hi = m_locked && (q < use_duty);
    exp_q.push_back({hi, is_wrap, is_disc});
    m_prev = q;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input int q, input bit dv, input int d, input bit rst);
    logic [2:0] e;
    q_in       = 8'(q);
    duty_valid = dv;
    duty       = 8'(d);
    reset      = rst;
    #1;
    chk("duty_ready", duty_ready, m_pending < 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    chk("pwm_out", pwm_out, e[2]);
    chk("wrap_tick", wrap_tick, e[1]);
    chk("sync_err", sync_err, e[0]);
    chk("state", dbg_state, m_locked ? RUN : SYNC);
    chk("wrap_cnt", wrap_cnt, m_wraps % 65536);
    chk("pwm_out_w4", s_pwm, e[2]);
    chk("wrap_cnt_w4", s_wrap_cnt, m_wraps % 16);
    if (pwm_out) hi_cnt++;
    if (wrap_tick) tick_cnt++;
    if (sync_err) err_cnt++;
  endtask

  task automatic ramp(input int from, input int to, input int acc_q, input int acc_d,
                      output int highs);
    int h0 = hi_cnt;
    for (int q = from; q <= to; q++) cycle(q, q == acc_q, acc_d, 1'b0);
    highs = hi_cnt - h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h;
    int t0;
    int e0;
    int q;
    int r;
    int d;
    reset      = 1'b1;
    q_in       = '0;
    duty       = '0;
    duty_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    cycle(0, 1'b0, 0, 1'b1);
    chk("rst_ready", duty_ready, 1);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);

    // Duty 64 accepted while unsynchronised: no output until the first wrap.
    ramp(0, 255, 0, 64, h);
    chk("sync_period_high", h, 0);
    t0 = tick_cnt;
    ramp(0, 255, -1, 0, h);
    chk("run64_high", h, 64);
    chk("tick_per_period", tick_cnt - t0, 1);

    // Mid-period update to 200 leaves the current period alone.
    ramp(0, 255, 100, 200, h);
    chk("cur_period_kept", h, 64);
    chk("ready_held", duty_ready, 0);
    ramp(0, 255, -1, 0, h);
    chk("run200_high", h, 200);

    // Accept exactly on the wrap: one intervening period at the old duty.
    ramp(0, 255, 0, 32, h);
    chk("wrap_accept_old", h, 200);
    ramp(0, 255, -1, 0, h);
    chk("wrap_accept_new", h, 32);

    // Upstream reload to 163 mid-ramp.
    ramp(0, 50, -1, 0, h);
    chk("pre_reload_high", h, 32);
    e0 = err_cnt;
    ramp(163, 255, -1, 0, h);
    chk("reload_low", h, 0);
    chk("reload_err_pulses", err_cnt - e0, 1);
    ramp(0, 255, -1, 0, h);
    chk("resync_high", h, 32);

    // Duty extremes.
    ramp(0, 255, 5, 0, h);
    chk("pre_duty0", h, 32);
    ramp(0, 255, -1, 0, h);
    chk("duty0_high", h, 0);
    ramp(0, 255, 5, 255, h);
    chk("pre_duty255", h, 0);
    ramp(0, 255, -1, 0, h);
    chk("duty255_high", h, 255);
    chk("duty255_last_low", pwm_out, 0);

    // Wrap counter rollover on the 4-bit instance.
    cycle(0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cycle(255, 1'b0, 0, 1'b0);
      cycle(0, 1'b0, 0, 1'b0);
    end
    chk("w4_at_max", s_wrap_cnt, 15);
    cycle(255, 1'b0, 0, 1'b0);
    cycle(0, 1'b0, 0, 1'b0);
    chk("w4_rollover", s_wrap_cnt, 0);
    chk("w16_count", wrap_cnt, 16);

    // Reset with a pending shadow value discards it.
    ramp(1, 255, -1, 0, h);
    ramp(0, 100, 10, 77, h);
    chk("pending_not_ready", duty_ready, 0);
    cycle(101, 1'b0, 0, 1'b1);
    chk("mid_rst_wrap_cnt", wrap_cnt, 0);
    chk("mid_rst_ready", duty_ready, 1);
    ramp(0, 255, -1, 0, h);
    ramp(0, 255, -1, 0, h);
    chk("shadow_discarded", h, 0);

    // Randomized traffic: mostly ramps, with holds, reloads, resets and updates.
    q = 0;
    for (int i = 0; i < 8000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 3) q = q;
      else if (r < 5) q = $urandom_range(0, 255);
      else q = (q + 1) % 256;
      r = $urandom_range(0, 3);
      d = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 255);
      cycle(q, $urandom_range(0, 7) == 0, d, $urandom_range(0, 1999) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_256_from_cnt.md
PWM_256_FROM_CNT -- requirements
Module: pwm_256_from_cnt

Interface
REQ-001 Parameter: WIDTH, 8, width of the counter value and of duty.
REQ-002 Parameter: WRAPW, 16, width of the wrap-event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 q_in  input  WIDTH  value from upstream free-running binary counter.
REQ-006 duty  input  WIDTH  requested duty value, qualified by duty_valid.
REQ-007 duty_valid  input  1  duty request present.
REQ-008 duty_ready  output  1  shadow register empty; request is accepted when duty_valid && duty_ready.
REQ-009 pwm_out  output  1  registered PWM output.
REQ-010 wrap_tick  output  1  one-cycle pulse, registered, on each detected counter wrap.
REQ-011 sync_err  output  1  one-cycle pulse, registered, on a counter discontinuity.
REQ-012 wrap_cnt  output  WRAPW  number of wraps seen since reset; wraps modulo 2^WRAPW.

Function
REQ-013 prev_q register SHALL hold the previous q_in; prev_valid SHALL be 0 for the first cycle after reset and 1 afterwards.
REQ-014 wrap SHALL be true when prev_valid && prev_q == 2^WIDTH-1 && q_in == 0.
REQ-015 disc SHALL be true when prev_valid && q_in != (prev_q+1) mod 2^WIDTH, covering upstream reload and hold.
REQ-016 FSM states: SYNC (output forced low) and RUN.
REQ-017 SYNC -> RUN on wrap; RUN -> SYNC on disc; all other cycles hold the state.
REQ-018 The shadow register SHALL load duty on accept and set shadow_valid; duty_ready = !shadow_valid.
REQ-019 On wrap with shadow_valid set, active_duty <= shadow and shadow_valid <= 0, in both SYNC and RUN.
REQ-020 eff_duty SHALL be shadow when (wrap && shadow_valid), otherwise active_duty.
REQ-021 pwm_out <= (next state is RUN) && (q_in < eff_duty); latency is 1 cycle from q_in.
REQ-022 duty 0 SHALL give constant low; duty 255 SHALL give high for 255 of 256 counts (low only at q_in = 255).
REQ-023 An accept in the same cycle as a wrap SHALL fill the shadow only, and commit at the following wrap.
REQ-024 A commit and an accept in the same cycle are impossible (ready = 0 while shadow is full); a commit frees ready on the next cycle.
REQ-025 wrap_tick <= wrap; sync_err <= disc; wrap_cnt SHALL increment on wrap and wrap 2^WRAPW-1 -> 0.
REQ-026 On disc, pwm_out SHALL be 0 on the next cycle; the shadow and active_duty SHALL be retained.

Reset
REQ-027 Reset SHALL force: state SYNC, prev_valid 0, active_duty 0, shadow_valid 0, pwm_out 0, wrap_tick 0, sync_err 0, wrap_cnt 0, duty_ready 1 on the next cycle.
REQ-028 Reset asserted mid-period SHALL discard any pending shadow value, with no commit.

Structure
REQ-029 Package pwm_pkg SHALL contain the WIDTH/WRAPW defaults and the SYNC/RUN state encodings.
REQ-030 Sub-module cnt_wrap_detect (prev_q, prev_valid, wrap, disc) SHALL be instantiated once; the FSM, shadow, compare and wrap counter stay in the top module.

Verification
REQ-031 Reset, then q_in ramps 0..255 repeatedly; duty = 64 accepted during SYNC -> pwm_out stays 0 until the first wrap, then is high for 64 cycles and low for 192 per period; wrap_tick once per 256 cycles.
REQ-032 In RUN with active_duty 64, accept 200 at q_in = 100 -> duty_ready 0 until the wrap; the next period shows 200 high cycles, and the current period is unchanged.
REQ-033 Accept 32 in the exact wrap cycle -> the shadow commits one full period later; the intervening period uses the old duty.
REQ-034 Upstream reloads q_in to 163 mid-ramp -> sync_err pulse, pwm_out 0 from the next cycle until the next wrap (255 -> 0), then resumes.
REQ-035 Duty 0 and 255 -> constant low, and high with a single low cycle at q_in = 255.
REQ-036 Preload 65535 wraps -> the next wrap gives wrap_cnt = 0; reset mid-period with a pending shadow -> wrap_cnt 0 and the shadow discarded.
